// File: rtl/serial_tx_port_pkg.sv
// Shared types and constants for the serial transmit port.
// Optional build macro: SERIAL_TX_PORT_PARITY_EN adds an even-parity bit to every frame.
package serial_tx_port_pkg;

  // Bus word type shared by the bus-facing logic
  typedef logic [15:0] word_t;

  // Transmit FSM encoding; the parity state exists only in the parity build
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef SERIAL_TX_PORT_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_t;

  // Status word bit positions
  localparam int STAT_EMPTY  = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_BUSY   = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 8;
  localparam int STAT_CNT_HI = 12;

  // Even parity over one data byte: XOR of all eight bits
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_tx_port_sync_fifo.sv
// Single-clock FIFO with push/pop, full/empty flags and an occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import serial_tx_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(1'b0));
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(1'b0);
      rd_ptr_r <= AW'(1'b0);
      count_r  <= CW'(1'b0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx_port.sv
// Bus-mapped serial transmitter: status/data register at BASE_ADDR,
// divisor register at BASE_ADDR+1, byte FIFO feeding an 8N1 line encoder.
// Optional build macro: SERIAL_TX_PORT_PARITY_EN (adds even parity, 11-bit frame).
module serial_tx_port
  import serial_tx_port_pkg::*;
#(
  parameter word_t BASE_ADDR   = 16'hC000,
  parameter int    FIFO_DEPTH  = 8,
  parameter word_t DEFAULT_DIV = 16'd104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_strobe,
  input  logic [15:0] read_bus,
  input  logic        write_strobe,
  input  logic [15:0] write_bus,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_out_en,
  output logic        tx
);

  localparam word_t DIV_ADDR = BASE_ADDR + 16'd1;
  localparam int    CW       = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic wr_data_s, wr_div_s, rd_stat_s, rd_div_s;
  assign wr_data_s = write_strobe && (write_bus == BASE_ADDR);
  assign wr_div_s  = write_strobe && (write_bus == DIV_ADDR);
  assign rd_stat_s = read_strobe  && (read_bus  == BASE_ADDR);
  assign rd_div_s  = read_strobe  && (read_bus  == DIV_ADDR);

  // Upper data byte is don't-care on data writes
  logic unused_bits_s;
  assign unused_bits_s = ^data_in[15:8];

  // FIFO interface
  logic          pop_s, full_s, empty_s;
  logic [7:0]    fifo_dout_s;
  logic [CW-1:0] count_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data_s),
    .pop   (pop_s),
    .din   (data_in[7:0]),
    .dout  (fifo_dout_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Registers
  word_t     divisor_r, cur_div_r, timer_r;
  logic      overflow_r, tx_r;
  tx_state_t state_r;
  logic [7:0] shift_r;
  logic [2:0] idx_r;

  // Next-state signals
  word_t     cur_div_next_s, timer_next_s, eff_div_s, status_s, rd_data_s;
  tx_state_t state_next_s;
  logic [7:0] shift_next_s;
  logic [2:0] idx_next_s;
  logic      tx_next_s, load_s, rd_en_s, ovf_next_s, ovf_event_s, timer_done_s;

`ifdef SERIAL_TX_PORT_PARITY_EN
  logic parity_r, parity_next_s;
`endif

  // A divisor of zero behaves as one bit per clock
  assign eff_div_s    = (divisor_r == 16'd0) ? 16'd1 : divisor_r;
  assign timer_done_s = (timer_r == 16'd0);
  // A push into a full FIFO is lost unless the FSM pops in the same cycle
  assign ovf_event_s  = wr_data_s && full_s && !pop_s;
  assign tx           = tx_r;

  // Status word assembly
  always_comb begin
    status_s                          = 16'h0000;
    status_s[STAT_EMPTY]              = empty_s;
    status_s[STAT_FULL]               = full_s;
    status_s[STAT_BUSY]               = (state_r != ST_IDLE);
    status_s[STAT_OVF]                = overflow_r;
    status_s[STAT_CNT_HI:STAT_CNT_LO] = 5'(count_s);
  end

  // Read response mux and sticky overflow update (new event beats read-clear)
  always_comb begin
    rd_data_s  = 16'h0000;
    rd_en_s    = 1'b0;
    ovf_next_s = overflow_r;
    if (rd_stat_s) begin
      rd_data_s = status_s;
      rd_en_s   = 1'b1;
    end else if (rd_div_s) begin
      rd_data_s = divisor_r;
      rd_en_s   = 1'b1;
    end else begin
      rd_en_s   = 1'b0;
    end
    if (ovf_event_s) begin
      ovf_next_s = 1'b1;
    end else if (rd_stat_s) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = overflow_r;
    end
  end

  // Bus-side registers: divisor, overflow flag and registered read response
  always_ff @(posedge clk) begin
    if (reset) begin
      divisor_r   <= DEFAULT_DIV;
      overflow_r  <= 1'b0;
      data_out    <= 16'h0000;
      data_out_en <= 1'b0;
    end else begin
      if (wr_div_s) begin
        divisor_r <= data_in;
      end
      overflow_r  <= ovf_next_s;
      data_out    <= rd_data_s;
      data_out_en <= rd_en_s;
    end
  end

  // Transmit FSM next-state and line value; each bit lasts cur_div_r clocks
  always_comb begin
    state_next_s   = state_r;
    tx_next_s      = tx_r;
    shift_next_s   = shift_r;
    idx_next_s     = idx_r;
    timer_next_s   = timer_r;
    cur_div_next_s = cur_div_r;
    load_s         = 1'b0;
    pop_s          = 1'b0;
`ifdef SERIAL_TX_PORT_PARITY_EN
    parity_next_s  = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          load_s = 1'b1;
        end else begin
          tx_next_s = 1'b1;
        end
      end
      ST_START: begin
        if (timer_done_s) begin
          state_next_s = ST_DATA;
          tx_next_s    = shift_r[0];
          shift_next_s = {1'b0, shift_r[7:1]};
          idx_next_s   = 3'd0;
          timer_next_s = cur_div_r - 16'd1;
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (timer_done_s && (idx_r == 3'd7)) begin
`ifdef SERIAL_TX_PORT_PARITY_EN
          state_next_s = ST_PARITY;
          tx_next_s    = parity_r;
`else
          state_next_s = ST_STOP;
          tx_next_s    = 1'b1;
`endif
          timer_next_s = cur_div_r - 16'd1;
        end else if (timer_done_s) begin
          tx_next_s    = shift_r[0];
          shift_next_s = {1'b0, shift_r[7:1]};
          idx_next_s   = idx_r + 3'd1;
          timer_next_s = cur_div_r - 16'd1;
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
`ifdef SERIAL_TX_PORT_PARITY_EN
      ST_PARITY: begin
        if (timer_done_s) begin
          state_next_s = ST_STOP;
          tx_next_s    = 1'b1;
          timer_next_s = cur_div_r - 16'd1;
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (timer_done_s && !empty_s) begin
          load_s = 1'b1;
        end else if (timer_done_s) begin
          state_next_s = ST_IDLE;
          tx_next_s    = 1'b1;
        end else begin
          timer_next_s = timer_r - 16'd1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        tx_next_s    = 1'b1;
      end
    endcase
    // Frame start: pop the next byte, drive the start bit, latch the divisor
    if (load_s) begin
      pop_s          = 1'b1;
      state_next_s   = ST_START;
      tx_next_s      = 1'b0;
      shift_next_s   = fifo_dout_s;
      idx_next_s     = 3'd0;
      cur_div_next_s = eff_div_s;
      timer_next_s   = eff_div_s - 16'd1;
`ifdef SERIAL_TX_PORT_PARITY_EN
      parity_next_s  = even_parity(fifo_dout_s);
`endif
    end else begin
      pop_s = 1'b0;
    end
  end

  // Transmit FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      tx_r      <= 1'b1;
      shift_r   <= 8'h00;
      idx_r     <= 3'd0;
      timer_r   <= 16'd0;
      cur_div_r <= 16'd1;
`ifdef SERIAL_TX_PORT_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      tx_r      <= tx_next_s;
      shift_r   <= shift_next_s;
      idx_r     <= idx_next_s;
      timer_r   <= timer_next_s;
      cur_div_r <= cur_div_next_s;
`ifdef SERIAL_TX_PORT_PARITY_EN
      parity_r  <= parity_next_s;
`endif
    end
  end

endmodule

// File: tb/tb_serial_tx_port.sv
// Directed bench for serial_tx_port: register access, frame shapes,
// overflow, divisor hand-over, back-to-back frames and mid-frame reset.
// Honours SERIAL_TX_PORT_PARITY_EN for frame length and parity bit.
module tb_serial_tx_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        read_strobe, write_strobe;
  logic [15:0] read_bus, write_bus, data_in;
  logic [15:0] data_out;
  logic        data_out_en;
  logic        tx;

  int total = 0;
  int bad   = 0;
  int lead_a, lead_b, lead_c, zeros;

  always #5 clk = ~clk;

  serial_tx_port #(
    .BASE_ADDR   (16'hC000),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd104)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read_strobe  (read_strobe),
    .read_bus     (read_bus),
    .write_strobe (write_strobe),
    .write_bus    (write_bus),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_out_en  (data_out_en),
    .tx           (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a negedge; one-cycle write strobe
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    write_strobe = 1'b1;
    write_bus    = addr;
    data_in      = data;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  // Called just after a negedge; response must appear next cycle for one cycle only
  task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    read_strobe = 1'b1;
    read_bus    = addr;
    @(negedge clk);
    read_strobe = 1'b0;
    check({tag, " en"}, data_out_en, 1'b1);
    check({tag, " data"}, data_out, exp);
    @(negedge clk);
    check({tag, " en drop"}, data_out_en, 1'b0);
  endtask

  task automatic wait_tx_low(output int lead);
    lead = 0;
    do begin
      @(negedge clk);
      lead++;
    end while (tx !== 1'b0 && lead < 4000);
    check("frame start seen", tx, 1'b0);
  endtask

  // Samples the whole frame at negedges, counting cycles each bit holds its value
  task automatic expect_frame(input logic [7:0] b, input int div, input string tag, output int lead);
    logic bits [11];
    int nb;
    int good;
    wait_tx_low(lead);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef SERIAL_TX_PORT_PARITY_EN
    bits[9]  = ^b;
    bits[10] = 1'b1;
    nb = 11;
`else
    bits[9]  = 1'b1;
    bits[10] = 1'b1;
    nb = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      good = 0;
      for (int c = 0; c < div; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx === bits[i]) good++;
      end
      check($sformatf("%s bit%0d", tag, i), good, div);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; read_strobe = 1'b0; write_strobe = 1'b0;
    read_bus = 16'h0000; write_bus = 16'h0000; data_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst en", data_out_en, 1'b0);
    check("rst data", data_out, 16'h0000);
    reset = 1'b0;
    bus_read(16'hC000, 16'h0001, "rst status");
    bus_read(16'hC001, 16'h0068, "rst div");

    // Non-matching address gives no response
    read_strobe = 1'b1; read_bus = 16'hC002;
    @(negedge clk);
    read_strobe = 1'b0;
    check("nomatch en", data_out_en, 1'b0);
    check("nomatch data", data_out, 16'h0000);

    // Simultaneous read and write of the divisor: read sees the old value
    read_strobe = 1'b1; read_bus = 16'hC001;
    write_strobe = 1'b1; write_bus = 16'hC001; data_in = 16'h0004;
    @(negedge clk);
    read_strobe = 1'b0; write_strobe = 1'b0;
    check("rw same en", data_out_en, 1'b1);
    check("rw same old div", data_out, 16'h0068);
    @(negedge clk);
    bus_read(16'hC001, 16'h0004, "div4");

    // DIV=4 frame of 0xA5 with a busy check mid-frame and idle afterwards
    bus_write(16'hC000, 16'h12A5);
    fork
      expect_frame(8'hA5, 4, "f_a5", lead_a);
      begin
        repeat (10) @(negedge clk);
        bus_read(16'hC000, 16'h0005, "busy mid");
      end
    join
    @(negedge clk);
    bus_read(16'hC000, 16'h0001, "idle after");

    // Overflow: start one frame at DIV=104, then push 9 more (one dropped)
    bus_write(16'hC001, 16'd104);
    bus_write(16'hC000, 16'h0011);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 9; i++) bus_write(16'hC000, 16'h0020 + 16'(i));
    bus_read(16'hC000, 16'h080E, "ovf set");
    bus_read(16'hC000, 16'h0806, "ovf clear");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_read(16'hC000, 16'h0001, "rst2 status");

    // Divisor change mid-frame applies only from the next frame
    bus_write(16'hC001, 16'd6);
    bus_write(16'hC000, 16'h003C);
    fork
      expect_frame(8'h3C, 6, "f_div6", lead_a);
      begin
        repeat (20) @(negedge clk);
        bus_write(16'hC001, 16'd2);
        bus_write(16'hC000, 16'h00C3);
      end
    join
    expect_frame(8'hC3, 2, "f_div2", lead_b);
    check("div change gap", lead_b, 1);
    bus_read(16'hC001, 16'h0002, "div2 rd");

    // Three back-to-back frames at DIV=1 with no idle gap
    @(negedge clk);
    bus_write(16'hC001, 16'd1);
    fork
      begin
        expect_frame(8'h5A, 1, "f_b2b0", lead_a);
        expect_frame(8'h81, 1, "f_b2b1", lead_b);
        expect_frame(8'h7E, 1, "f_b2b2", lead_c);
        check("b2b gap1", lead_b, 1);
        check("b2b gap2", lead_c, 1);
      end
      begin
        bus_write(16'hC000, 16'h005A);
        bus_write(16'hC000, 16'h0081);
        bus_write(16'hC000, 16'h007E);
      end
    join
    @(negedge clk);
    bus_read(16'hC000, 16'h0001, "b2b empty");

    // Divisor 0 reads back as 0 but times bits as 1 clock
    bus_write(16'hC001, 16'd0);
    bus_read(16'hC001, 16'h0000, "div0 rd");
    bus_write(16'hC000, 16'h00F0);
    expect_frame(8'hF0, 1, "f_div0", lead_a);
    @(negedge clk);

`ifdef SERIAL_TX_PORT_PARITY_EN
    // Parity bit: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0)
    bus_write(16'hC001, 16'd2);
    bus_write(16'hC000, 16'h0007);
    expect_frame(8'h07, 2, "f_par07", lead_a);
    bus_write(16'hC000, 16'h0003);
    expect_frame(8'h03, 2, "f_par03", lead_a);
    @(negedge clk);
`endif

    // Reset during data bit 3 with two bytes still queued
    bus_write(16'hC001, 16'd4);
    fork
      begin
        wait_tx_low(lead_a);
        repeat (17) @(negedge clk);
        check("pre-rst tx", tx, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("mid rst tx", tx, 1'b1);
        reset = 1'b0;
      end
      begin
        bus_write(16'hC000, 16'h0000);
        bus_write(16'hC000, 16'h0000);
        bus_write(16'hC000, 16'h0000);
      end
    join
    bus_read(16'hC000, 16'h0001, "mid rst status");
    zeros = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("no frames after rst", zeros, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
